// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline hazard/stall controller: data-memory wait handshake, wait-timeout watchdog, sticky halt.
// Optional saturating stall/bubble performance counters are built when PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
   parameter int              IW          = 4,
   parameter int              RW          = 4,
   parameter int              SW          = 2,
   parameter logic [RW-1:0]   REG_NONE    = {RW{1'b1}},
   parameter int              MEM_TIMEOUT = 255,
   parameter int              CNTW        = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [IW-1:0]   D_icode,
   input  logic [IW-1:0]   E_icode,
   input  logic [IW-1:0]   M_icode,
   input  logic [RW-1:0]   d_srcA,
   input  logic [RW-1:0]   d_srcB,
   input  logic [RW-1:0]   E_dstM,
   input  logic            e_cnd,
   input  logic [SW-1:0]   m_stat,
   input  logic [SW-1:0]   W_stat,
   input  logic            M_mem_req,
   input  logic            dmem_ready,
   output logic            F_stall,
   output logic            D_stall,
   output logic            D_bubble,
   output logic            E_stall,
   output logic            E_bubble,
   output logic            M_stall,
   output logic            M_bubble,
   output logic            W_stall,
   output logic            W_bubble,
   output logic            set_cc,
   output logic            halted,
   output logic            mem_fault,
   output logic [1:0]      state,
   output logic [CNTW-1:0] stall_cnt,
   output logic [CNTW-1:0] bubble_cnt
);

   typedef enum logic [1:0] {RUN = 2'd0, MWAIT = 2'd1, HALT = 2'd2} state_e;

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);

   localparam logic [IW-1:0] I_MRMOVQ = IW'(5);
   localparam logic [IW-1:0] I_OPQ    = IW'(6);
   localparam logic [IW-1:0] I_JXX    = IW'(7);
   localparam logic [IW-1:0] I_RET    = IW'(9);
   localparam logic [IW-1:0] I_POPQ   = IW'(11);

   state_e           state_q, state_d;
   logic [WCW-1:0]   wcnt_q, wcnt_d;
   logic             halted_q, halted_d;
   logic             fault_q, fault_d;

   logic load_use, mispredict, ret, mem_wait, w_exc, m_exc, exc;

   assign load_use   = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && (E_dstM != REG_NONE) &&
                       (E_dstM == d_srcA || E_dstM == d_srcB);
   assign mispredict = (E_icode == I_JXX) && !e_cnd;
   assign ret        = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
   assign mem_wait   = M_mem_req && !dmem_ready;
   assign w_exc      = |W_stat;
   assign m_exc      = |m_stat;
   assign exc        = m_exc || w_exc;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RUN;
         wcnt_q   <= '0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
      end
   end

   // The timeout fires on the edge where the counter would reach MEM_TIMEOUT-1, i.e. the
   // MEM_TIMEOUT-th edge after mem_wait first asserts in RUN (MEM_TIMEOUT >= 2 assumed).
   always_comb begin
      // NOTE: defaults first so every path assigns every signal and no latch is inferred.
      state_d  = state_q;
      wcnt_d   = '0;
      halted_d = halted_q;
      fault_d  = fault_q;
      unique case (state_q)
         RUN: begin
            if (w_exc) begin
               state_d  = HALT;
               halted_d = 1'b1;
            end else if (mem_wait) begin
               state_d = MWAIT;
            end
         end
         MWAIT: begin
            if (w_exc) begin
               state_d  = HALT;
               halted_d = 1'b1;
            end else if (mem_wait) begin
               if (wcnt_q + WCW'(1) == WCW'(MEM_TIMEOUT - 1)) begin
                  state_d = HALT;
                  fault_d = 1'b1;
               end else begin
                  wcnt_d = wcnt_q + WCW'(1);
               end
            end else begin
               state_d = RUN;
            end
         end
         HALT: begin
            if (w_exc) halted_d = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b0;
      E_stall  = 1'b0;
      E_bubble = 1'b0;
      M_stall  = 1'b0;
      M_bubble = 1'b0;
      W_stall  = 1'b0;
      W_bubble = 1'b0;
      set_cc   = 1'b0;
      // Controls are forced low while reset is held, independent of the registered state.
      if (rst_n) begin
         if (state_q == HALT || w_exc) begin
            F_stall  = 1'b1;
            W_stall  = 1'b1;
            M_bubble = 1'b1;
         end else if (mem_wait) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_stall  = 1'b1;
            M_stall  = 1'b1;
            W_bubble = 1'b1;
         end else begin
            if (mispredict) begin
               D_bubble = 1'b1;
               E_bubble = 1'b1;
            end
            if (load_use) begin
               F_stall  = 1'b1;
               D_stall  = 1'b1;
               E_bubble = 1'b1;
            end
            if (ret && !load_use) begin
               F_stall  = 1'b1;
               D_bubble = 1'b1;
            end
            if (m_exc) M_bubble = 1'b1;
         end
         set_cc = (E_icode == I_OPQ) && !exc && (state_q != HALT) && !mem_wait;
      end
   end

   assign state     = state_q;
   assign halted    = halted_q;
   assign mem_fault = fault_q;

`ifdef PERF_CNT_EN
   logic [CNTW-1:0] stall_cnt_q, bubble_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (F_stall && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + CNTW'(1);
         if ((D_bubble || E_bubble) && !(&bubble_cnt_q))
            bubble_cnt_q <= bubble_cnt_q + CNTW'(1);
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4); expected values are hand-computed.
// Counter expectations follow PERF_CNT_EN when the bench is built with that macro.
module tb_pipe_hazard_ctrl;

   localparam int CNTW = 16;
`ifdef PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [3:0]      D_icode, E_icode, M_icode;
   logic [3:0]      d_srcA, d_srcB, E_dstM;
   logic            e_cnd;
   logic [1:0]      m_stat, W_stat;
   logic            M_mem_req, dmem_ready;
   logic            F_stall, D_stall, D_bubble, E_stall, E_bubble;
   logic            M_stall, M_bubble, W_stall, W_bubble, set_cc;
   logic            halted, mem_fault;
   logic [1:0]      state;
   logic [CNTW-1:0] stall_cnt, bubble_cnt;

   int checks = 0;
   int errors = 0;

   // Packed view: F_stall D_stall D_bubble E_stall E_bubble M_stall M_bubble W_stall W_bubble set_cc
   logic [9:0] ctl;
   assign ctl = {F_stall, D_stall, D_bubble, E_stall, E_bubble,
                 M_stall, M_bubble, W_stall, W_bubble, set_cc};

   localparam logic [9:0] C_NONE  = 10'b00000_00000;
   localparam logic [9:0] C_CC    = 10'b00000_00001;
   localparam logic [9:0] C_LU    = 10'b11001_00000;
   localparam logic [9:0] C_MISP  = 10'b00101_00000;
   localparam logic [9:0] C_RET   = 10'b10100_00000;
   localparam logic [9:0] C_MEXC  = 10'b00000_01000;
   localparam logic [9:0] C_MWAIT = 10'b11010_10010;
   localparam logic [9:0] C_HALT  = 10'b10000_01100;

   pipe_hazard_ctrl #(
      .IW(4), .RW(4), .SW(2), .REG_NONE(4'hF), .MEM_TIMEOUT(4), .CNTW(CNTW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
      .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd),
      .m_stat(m_stat), .W_stat(W_stat), .M_mem_req(M_mem_req), .dmem_ready(dmem_ready),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
      .E_stall(E_stall), .E_bubble(E_bubble), .M_stall(M_stall), .M_bubble(M_bubble),
      .W_stall(W_stall), .W_bubble(W_bubble), .set_cc(set_cc),
      .halted(halted), .mem_fault(mem_fault), .state(state),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   always #20 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
      d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_cnd = 1'b1;
      m_stat = 2'd0; W_stat = 2'd0; M_mem_req = 1'b0; dmem_ready = 1'b1;
   endtask

   // Advance past the next rising edge; outputs are then sampled mid-cycle.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      idle();
      E_icode = 4'h6;
      rst_n = 1'b0;
      #5;
      check("reset_ctl", 32'(ctl), 32'(C_NONE));
      check("reset_state", 32'(state), 32'd0);
      check("reset_flags", 32'({halted, mem_fault}), 32'd0);
      check("reset_cnt", 32'(stall_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      settle();
      check("opq_set_cc", 32'(ctl), 32'(C_CC));

      // Combinational hazard cases, all within one cycle.
      tick();
      idle(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; settle();
      check("load_use_mrmov", 32'(ctl), 32'(C_LU));
      idle(); E_icode = 4'h5; E_dstM = 4'hF; d_srcB = 4'hF; settle();
      check("reg_none_no_hazard", 32'(ctl), 32'(C_NONE));
      idle(); E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4; settle();
      check("load_use_popq", 32'(ctl), 32'(C_LU));
      idle(); E_icode = 4'h7; e_cnd = 1'b0; settle();
      check("mispredict", 32'(ctl), 32'(C_MISP));
      idle(); D_icode = 4'h9; settle();
      check("ret_in_decode", 32'(ctl), 32'(C_RET));
      idle(); M_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2; settle();
      check("ret_with_load_use", 32'(ctl), 32'(C_LU));
      idle(); E_icode = 4'h6; m_stat = 2'd1; settle();
      check("m_stat_bubble", 32'(ctl), 32'(C_MEXC));
      idle(); settle();

      // Memory wait: ready low for 3 cycles then high.
      tick();
      idle(); E_icode = 4'h6; M_mem_req = 1'b1; dmem_ready = 1'b0; settle();
      check("mwait_c1_ctl", 32'(ctl), 32'(C_MWAIT));
      check("mwait_c1_state", 32'(state), 32'd0);
      tick();
      check("mwait_c2_ctl", 32'(ctl), 32'(C_MWAIT));
      check("mwait_c2_state", 32'(state), 32'd1);
      tick();
      check("mwait_c3_ctl", 32'(ctl), 32'(C_MWAIT));
      tick();
      dmem_ready = 1'b1; settle();
      check("mwait_done_ctl", 32'(ctl), 32'(C_CC));
      check("mwait_done_state", 32'(state), 32'd1);
      tick();
      idle(); settle();
      check("mwait_back_run", 32'(state), 32'd0);
      check("stall_cnt_3", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);
      check("bubble_cnt_0", 32'(bubble_cnt), 32'd0);

      // Timeout watchdog with ready held low.
      M_mem_req = 1'b1; dmem_ready = 1'b0;
      tick(); tick(); tick();
      check("timeout_e3_state", 32'(state), 32'd1);
      check("timeout_e3_fault", 32'(mem_fault), 32'd0);
      tick();
      check("timeout_e4_state", 32'(state), 32'd2);
      check("timeout_e4_flags", 32'({halted, mem_fault}), 32'b01);
      check("timeout_halt_ctl", 32'(ctl), 32'(C_HALT));
      idle(); E_icode = 4'h6;
      tick(); tick();
      check("halt_sticky_ctl", 32'(ctl), 32'(C_HALT));
      check("halt_sticky_state", 32'(state), 32'd2);

      // Reset out of HALT.
      rst_n = 1'b0; settle();
      check("rst_from_halt_ctl", 32'(ctl), 32'(C_NONE));
      check("rst_from_halt_st", 32'({state, halted, mem_fault}), 32'd0);
      tick();
      rst_n = 1'b1; idle(); settle();

      // W_stat exception during OPq: set_cc suppressed, halted rises next edge and sticks.
      E_icode = 4'h6; W_stat = 2'd2; settle();
      check("wstat_ctl", 32'(ctl), 32'(C_HALT));
      check("wstat_halted_pre", 32'(halted), 32'd0);
      tick();
      W_stat = 2'd0; settle();
      check("wstat_halted_post", 32'({state, halted, mem_fault}), 32'b1010);
      check("wstat_halt_ctl", 32'(ctl), 32'(C_HALT));
      tick();
      check("wstat_halted_stays", 32'(halted), 32'd1);

      // mem_wait and W_stat on the same edge: HALT wins.
      rst_n = 1'b0; settle();
      rst_n = 1'b1; idle();
      tick();
      M_mem_req = 1'b1; dmem_ready = 1'b0; W_stat = 2'd1; settle();
      check("tie_ctl", 32'(ctl), 32'(C_HALT));
      tick();
      check("tie_state", 32'({state, halted, mem_fault}), 32'b1010);

      // Reset dropped mid-MWAIT, then normal operation.
      rst_n = 1'b0; settle();
      rst_n = 1'b1; idle();
      tick();
      M_mem_req = 1'b1; dmem_ready = 1'b0;
      tick(); tick();
      check("pre_rst_state", 32'(state), 32'd1);
      rst_n = 1'b0; settle();
      check("rst_mid_wait_ctl", 32'(ctl), 32'(C_NONE));
      check("rst_mid_wait_state", 32'(state), 32'd0);
      check("rst_mid_wait_cnt", 32'(stall_cnt), 32'd0);
      tick();
      rst_n = 1'b1; idle(); E_icode = 4'h6; settle();
      check("post_rst_cc", 32'(ctl), 32'(C_CC));
      tick();
      check("post_rst_state", 32'(state), 32'd0);

      // Bubble counter over two mispredict edges.
      idle(); E_icode = 4'h7; e_cnd = 1'b0;
      tick(); tick();
      idle(); settle();
      check("bubble_cnt_2", 32'(bubble_cnt), PERF ? 32'd2 : 32'd0);
      check("stall_cnt_still_0", 32'(stall_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard and stall controller for the Y86-64 five-stage pipeline. It replaces the purely combinational hazard logic with a unit that covers three cases: data-memory wait states (ready handshake), a timeout watchdog on those waits, and a sticky halt state. It sits beside the stage registers and drives their stall/bubble inputs and the condition-code write enable. Optional saturating performance counters are included.

## Interface
- IW, 4, icode width
- RW, 4, register-ID width
- SW, 2, status width; status 0 = AOK, any nonzero = exception
- REG_NONE, 4'hF, register ID meaning "no register"; never causes a hazard
- MEM_TIMEOUT, 255, maximum consecutive memory-wait cycles before fault
- CNTW, 16, performance counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- D_icode, E_icode, M_icode  in  IW  icode in Decode/Execute/Memory
- d_srcA, d_srcB  in  RW  decode source registers
- E_dstM  in  RW  load destination in Execute
- e_cnd  in  1  branch condition from Execute
- m_stat, W_stat  in  SW  Memory-stage/Writeback status
- M_mem_req  in  1  Memory stage is performing a data access
- dmem_ready  in  1  data memory completes the access this cycle
- F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall, W_bubble  out  1  stage controls
- set_cc  out  1  condition-code write enable
- halted  out  1  sticky halt flag
- mem_fault  out  1  sticky timeout flag
- state  out  2  FSM state: 0 RUN, 1 MWAIT, 2 HALT
- stall_cnt, bubble_cnt  out  CNTW  performance counters

## Operation
- Derived terms:
  - load_use = (E_icode==5 or 11) and E_dstM!=REG_NONE and (E_dstM==d_srcA or E_dstM==d_srcB)
  - mispredict = E_icode==7 and !e_cnd
  - ret = any of D/E/M_icode==9
  - mem_wait = M_mem_req and !dmem_ready
  - exc = m_stat!=0 or W_stat!=0
- Priority, highest first:
  - HALT state or W_stat!=0: F_stall, W_stall, M_bubble = 1; set_cc = 0; all others 0.
  - mem_wait: F_stall, D_stall, E_stall, M_stall = 1; W_bubble = 1; set_cc = 0.
  - Otherwise, combine the following:
    - mispredict: D_bubble, E_bubble.
    - load_use: F_stall, D_stall, E_bubble.
    - ret and !load_use: F_stall, D_bubble.
    - m_stat!=0: M_bubble.
- set_cc = (E_icode==6) and !exc and not in HALT and !mem_wait.
- FSM transitions:
  - RUN -> MWAIT when mem_wait.
  - MWAIT -> RUN when dmem_ready.
  - MWAIT -> HALT when the wait counter reaches MEM_TIMEOUT-1 while mem_wait is still high; this sets mem_fault.
  - Any state -> HALT when W_stat!=0; this sets halted.
  - HALT is left only by reset.
- Wait counter (width ceil(log2(MEM_TIMEOUT+1))):
  - Increments each MWAIT cycle with mem_wait high.
  - Clears on leaving MWAIT.
- A mem_wait beginning on the same edge as W_stat!=0: HALT wins.

## Timing
- Stage controls and set_cc are combinational from inputs plus the registered state, so they take effect in the same cycle.
- state, halted, mem_fault, wait counter and perf counters update on the rising edge of clk.
- halted rises one edge after W_stat!=0 is first seen. Stage outputs respond in that same cycle through the combinational W_stat term.
- Timeout: with dmem_ready held low, mem_fault rises on the MEM_TIMEOUT-th edge after mem_wait first asserts.
- Reset (asynchronous, any time including mid-wait):
  - state=RUN, wait counter=0, halted=0, mem_fault=0, stall_cnt=0, bubble_cnt=0.
  - While rst_n is low, every stall/bubble output and set_cc is 0.

## Configuration
- PERF_CNT_EN defined:
  - stall_cnt increments on every cycle where F_stall=1.
  - bubble_cnt increments on every cycle where D_bubble or E_bubble is 1.
  - Both saturate at all-ones.
- PERF_CNT_EN undefined: the counters are not built and stall_cnt, bubble_cnt are tied to 0.

## Test plan
- E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0.
- E_icode=5, E_dstM=15, d_srcB=15 -> no stall; E_icode=7, e_cnd=0 -> D_bubble=E_bubble=1.
- M_mem_req=1, dmem_ready low for 3 cycles then high -> F/D/E/M_stall and W_bubble=1 for exactly 3 cycles; state 0->1->0; stall_cnt=3 with PERF_CNT_EN.
- MEM_TIMEOUT=4, dmem_ready held low -> mem_fault=1 and state=2 after 4 edges; W_stall=M_bubble=1 until reset.
- W_stat=2 for one cycle during E_icode=6 -> set_cc=0; halted=1 next edge and stays after W_stat returns to 0.
- Drop rst_n mid-MWAIT -> all outputs 0 immediately, state=0; normal operation after release.
